// File: rtl/tcb_argmax_seq.sv
// Sequential arg-max over a registered score vector, comparing LANES candidates per cycle.
// Ties resolve to the lowest index; the result is held under ready/ack back-pressure.
module tcb_argmax_seq #(
  parameter int N_CLASS = 10,
  parameter int SCORE_W = 42,
  parameter int SIGNED  = 1,
  parameter int LANES   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [N_CLASS*SCORE_W-1:0] layer_out,
  output logic                       accept,
  output logic                       ready,
  input  logic                       ack,
  output logic [31:0]                predict,
  output logic [SCORE_W-1:0]         max_score,
  output logic                       tie
);

  localparam int IDX_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam int PTR_W = $clog2(N_CLASS + LANES + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                     state;
  state_t                     state_next;
  logic [N_CLASS*SCORE_W-1:0] vec;
  logic [SCORE_W-1:0]         best_score;
  logic [IDX_W-1:0]           best_idx;
  logic                       best_tie;
  logic [PTR_W-1:0]           ptr;
  logic [SCORE_W-1:0]         scan_score;
  logic [IDX_W-1:0]           scan_idx;
  logic                       scan_tie;
  logic                       scan_last;
  logic [IDX_W-1:0]           predict_idx;

  function automatic logic greater(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // One scan step: walk this cycle's lanes in ascending index order.
  always_comb begin : scan_step
    int                 j;
    logic [SCORE_W-1:0] cand;
    j          = 0;
    cand       = '0;
    scan_score = best_score;
    scan_idx   = best_idx;
    scan_tie   = best_tie;
    for (int l = 0; l < LANES; l++) begin
      j = int'(ptr) + l;
      if (j < N_CLASS) begin
        cand = vec[j*SCORE_W +: SCORE_W];
        if (greater(cand, scan_score)) begin
          scan_score = cand;
          scan_idx   = j[IDX_W-1:0];
          scan_tie   = 1'b0;
        end else if (cand == scan_score) begin
          scan_tie = 1'b1;
        end
      end
    end
    scan_last = (int'(ptr) + LANES >= N_CLASS);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid) state_next = (N_CLASS == 1) ? DONE : SCAN;
      SCAN:    if (scan_last) state_next = DONE;
      DONE:    if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output registers are written only on entry to DONE so scan progress never shows.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec         <= '0;
      best_score  <= '0;
      best_idx    <= '0;
      best_tie    <= 1'b0;
      ptr         <= '0;
      predict_idx <= '0;
      max_score   <= '0;
      tie         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            vec        <= layer_out;
            best_score <= layer_out[SCORE_W-1:0];
            best_idx   <= '0;
            best_tie   <= 1'b0;
            ptr        <= PTR_W'(1);
            if (N_CLASS == 1) begin
              predict_idx <= '0;
              max_score   <= layer_out[SCORE_W-1:0];
              tie         <= 1'b0;
            end
          end
        end
        SCAN: begin
          best_score <= scan_score;
          best_idx   <= scan_idx;
          best_tie   <= scan_tie;
          ptr        <= ptr + PTR_W'(LANES);
          if (scan_last) begin
            predict_idx <= scan_idx;
            max_score   <= scan_score;
            tie         <= scan_tie;
          end
        end
        default: ;
      endcase
    end
  end

  assign accept  = (state == IDLE) && !rst;
  assign ready   = (state == DONE);
  assign predict = 32'(predict_idx);

endmodule

// File: tb/tb_tcb_argmax_seq.sv
// Self-checking bench: four arg-max instances (LANES=1, LANES=4 signed/unsigned, N_CLASS=1)
// driven with directed and random vectors, compared against a plain arg-max reference model.
module tb_tcb_argmax_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         valid_a, ack_a, accept_a, ready_a, tie_a;
  logic [419:0] vec_a;
  logic [31:0]  predict_a;
  logic [41:0]  max_a;

  logic         valid_b, ack_b, accept_b, ready_b, tie_b;
  logic [419:0] vec_b;
  logic [31:0]  predict_b;
  logic [41:0]  max_b;
  logic         accept_c, ready_c, tie_c;
  logic [31:0]  predict_c;
  logic [41:0]  max_c;

  logic         valid_d, ack_d, accept_d, ready_d, tie_d;
  logic [41:0]  vec_d;
  logic [31:0]  predict_d;
  logic [41:0]  max_d;

  int errors = 0;
  int checks = 0;

  tcb_argmax_seq #(.N_CLASS(10), .SCORE_W(42), .SIGNED(1), .LANES(1)) u_a (
    .clk(clk), .rst(rst), .valid(valid_a), .layer_out(vec_a), .accept(accept_a),
    .ready(ready_a), .ack(ack_a), .predict(predict_a), .max_score(max_a), .tie(tie_a));

  tcb_argmax_seq #(.N_CLASS(10), .SCORE_W(42), .SIGNED(1), .LANES(4)) u_b (
    .clk(clk), .rst(rst), .valid(valid_b), .layer_out(vec_b), .accept(accept_b),
    .ready(ready_b), .ack(ack_b), .predict(predict_b), .max_score(max_b), .tie(tie_b));

  tcb_argmax_seq #(.N_CLASS(10), .SCORE_W(42), .SIGNED(0), .LANES(4)) u_c (
    .clk(clk), .rst(rst), .valid(valid_b), .layer_out(vec_b), .accept(accept_c),
    .ready(ready_c), .ack(ack_b), .predict(predict_c), .max_score(max_c), .tie(tie_c));

  tcb_argmax_seq #(.N_CLASS(1), .SCORE_W(42), .SIGNED(1), .LANES(1)) u_d (
    .clk(clk), .rst(rst), .valid(valid_d), .layer_out(vec_d), .accept(accept_d),
    .ready(ready_d), .ack(ack_d), .predict(predict_d), .max_score(max_d), .tie(tie_d));

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ordering key: signed scores sign-extend, unsigned scores zero-extend into 64 bits.
  function automatic longint scoreKey(input logic [41:0] x, input bit sgn);
    if (sgn) return longint'($signed(x));
    return longint'(x);
  endfunction

  task automatic refModel(input logic [419:0] v, input int n, input bit sgn,
                          output int idx, output logic [41:0] mx, output bit t);
    longint best;
    longint k;
    int     cnt;
    best = 0;
    cnt  = 0;
    idx  = 0;
    for (int i = 0; i < n; i++) begin
      k = scoreKey(v[i*42 +: 42], sgn);
      if (i == 0 || k > best) begin
        best = k;
        idx  = i;
        cnt  = 1;
      end else if (k == best) begin
        cnt++;
      end
    end
    mx = v[idx*42 +: 42];
    t  = (cnt > 1);
  endtask

  function automatic logic readyOf(input int g);
    if (g == 0) return ready_a;
    if (g == 1) return ready_b;
    return ready_d;
  endfunction

  function automatic logic [419:0] randVec(input int mode);
    logic [419:0] v;
    logic [63:0]  r;
    v = '0;
    for (int k = 0; k < 10; k++) begin
      case (mode)
        0: begin
          r = {$urandom, $urandom};
          v[k*42 +: 42] = r[41:0];
        end
        1: v[k*42 +: 42] = 42'($urandom_range(0, 6)) - 42'd3;
        default: begin
          case ($urandom_range(0, 3))
            0:       v[k*42 +: 42] = 42'h200_0000_0000;
            1:       v[k*42 +: 42] = 42'h1FF_FFFF_FFFF;
            2:       v[k*42 +: 42] = 42'h0;
            default: v[k*42 +: 42] = 42'h3FF_FFFF_FFFF;
          endcase
        end
      endcase
    end
    return v;
  endfunction

  // Present a vector for one accept edge, then count edges until ready.
  task automatic applyStimulus(input int g, input logic [419:0] v, output int lat);
    @(negedge clk);
    if (g == 0) begin vec_a = v; valid_a = 1'b1; end
    else if (g == 1) begin vec_b = v; valid_b = 1'b1; end
    else begin vec_d = v[41:0]; valid_d = 1'b1; end
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    valid_d = 1'b0;
    vec_a = ~vec_a;
    vec_b = ~vec_b;
    vec_d = ~vec_d;
    lat = 0;
    while (readyOf(g) !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic checkResult(input string tag, input int g, input logic [419:0] v, input int lat);
    int         idx;
    logic [41:0] mx;
    bit         t;
    int         n;
    int         s;
    n = (g == 2) ? 1 : 10;
    s = (g == 0) ? 9 : ((g == 1) ? 3 : 0);
    checkOutput({tag, "_lat"}, 64'(lat), 64'(s));
    refModel(v, n, 1'b1, idx, mx, t);
    if (g == 0) begin
      checkOutput({tag, "_predict"}, 64'(predict_a), 64'(idx));
      checkOutput({tag, "_max"}, 64'(max_a), 64'(mx));
      checkOutput({tag, "_tie"}, 64'(tie_a), 64'(t));
    end else if (g == 1) begin
      checkOutput({tag, "_predict_s"}, 64'(predict_b), 64'(idx));
      checkOutput({tag, "_max_s"}, 64'(max_b), 64'(mx));
      checkOutput({tag, "_tie_s"}, 64'(tie_b), 64'(t));
      checkOutput({tag, "_ready_u"}, 64'(ready_c), 64'(1));
      refModel(v, n, 1'b0, idx, mx, t);
      checkOutput({tag, "_predict_u"}, 64'(predict_c), 64'(idx));
      checkOutput({tag, "_max_u"}, 64'(max_c), 64'(mx));
      checkOutput({tag, "_tie_u"}, 64'(tie_c), 64'(t));
    end else begin
      checkOutput({tag, "_predict"}, 64'(predict_d), 64'(idx));
      checkOutput({tag, "_max"}, 64'(max_d), 64'(mx));
      checkOutput({tag, "_tie"}, 64'(tie_d), 64'(t));
    end
  endtask

  task automatic ackResult(input string tag, input int g);
    @(negedge clk);
    if (g == 0) ack_a = 1'b1; else if (g == 1) ack_b = 1'b1; else ack_d = 1'b1;
    @(posedge clk);
    #1;
    ack_a = 1'b0;
    ack_b = 1'b0;
    ack_d = 1'b0;
    if (g == 0) begin
      checkOutput({tag, "_ready_drop"}, 64'(ready_a), 64'(0));
      checkOutput({tag, "_accept_back"}, 64'(accept_a), 64'(1));
    end else if (g == 1) begin
      checkOutput({tag, "_ready_drop"}, 64'({ready_b, ready_c}), 64'(0));
      checkOutput({tag, "_accept_back"}, 64'({accept_b, accept_c}), 64'(3));
    end else begin
      checkOutput({tag, "_ready_drop"}, 64'(ready_d), 64'(0));
      checkOutput({tag, "_accept_back"}, 64'(accept_d), 64'(1));
    end
  endtask

  initial begin
    logic [419:0] v;
    int           lat;
    int           bad;
    int           highs;
    logic         prev;
    logic [31:0]  p0;
    logic [41:0]  m0;
    logic         t0;

    rst = 1'b1;
    valid_a = 1'b0; ack_a = 1'b0; vec_a = '0;
    valid_b = 1'b0; ack_b = 1'b0; vec_b = '0;
    valid_d = 1'b0; ack_d = 1'b0; vec_d = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("accept_in_reset", 64'({accept_a, accept_b, accept_c, accept_d}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_accept", 64'({accept_a, accept_b, accept_c, accept_d}), 64'hF);
    checkOutput("reset_ready", 64'({ready_a, ready_b, ready_c, ready_d}), 64'(0));
    checkOutput("reset_predict", 64'(predict_a | predict_b | predict_c | predict_d), 64'(0));
    checkOutput("reset_max", 64'(max_a | max_b | max_c | max_d), 64'(0));
    checkOutput("reset_tie", 64'({tie_a, tie_b, tie_c, tie_d}), 64'(0));

    // Ascending scores with class 7 far ahead.
    v = '0;
    for (int k = 0; k < 10; k++) v[k*42 +: 42] = 42'(k * 100);
    v[7*42 +: 42] = 42'd5000;
    applyStimulus(0, v, lat);
    checkResult("k100", 0, v, lat);
    checkOutput("k100_const_predict", 64'(predict_a), 64'(7));
    checkOutput("k100_const_max", 64'(max_a), 64'(5000));

    // Back-pressure: result must sit still while ack is low.
    p0 = predict_a; m0 = max_a; t0 = tie_a;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (ready_a !== 1'b1 || accept_a !== 1'b0 || predict_a !== p0 || max_a !== m0 || tie_a !== t0)
        bad++;
    end
    checkOutput("hold_20_cycles", 64'(bad), 64'(0));
    ackResult("k100", 0);
    checkOutput("hold_after_ack", 64'(predict_a), 64'(7));

    // All negative with a tie between classes 3 and 8.
    v = '0;
    for (int k = 0; k < 10; k++) v[k*42 +: 42] = 42'(-50);
    v[3*42 +: 42] = 42'h3FF_FFFF_FFFF;
    v[8*42 +: 42] = 42'h3FF_FFFF_FFFF;
    applyStimulus(0, v, lat);
    checkResult("neg_tie", 0, v, lat);
    checkOutput("neg_tie_const_predict", 64'(predict_a), 64'(3));
    checkOutput("neg_tie_const_max", 64'(max_a), 64'h3FF_FFFF_FFFF);
    checkOutput("neg_tie_const_tie", 64'(tie_a), 64'(1));
    ackResult("neg_tie", 0);

    v = '0;
    for (int k = 0; k < 10; k++) v[k*42 +: 42] = 42'(k * 10);
    v[2*42 +: 42] = 42'd999;
    applyStimulus(0, v, lat);
    checkResult("class2", 0, v, lat);
    checkOutput("class2_const_predict", 64'(predict_a), 64'(2));
    ackResult("class2", 0);

    // Extremes at both ends of the 4-lane pair: signedness decides the winner.
    v = '0;
    v[9*42 +: 42] = 42'h1FF_FFFF_FFFF;
    v[0*42 +: 42] = 42'h200_0000_0000;
    applyStimulus(1, v, lat);
    checkResult("extremes", 1, v, lat);
    checkOutput("extremes_signed_predict", 64'(predict_b), 64'(9));
    checkOutput("extremes_unsigned_predict", 64'(predict_c), 64'(0));
    ackResult("extremes", 1);

    // Reset during scan cycle 4 aborts the vector.
    @(negedge clk);
    for (int k = 0; k < 10; k++) vec_a[k*42 +: 42] = 42'(k + 1);
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_ready", 64'(ready_a), 64'(0));
    checkOutput("abort_predict", 64'(predict_a), 64'(0));
    checkOutput("abort_max", 64'(max_a), 64'(0));
    checkOutput("abort_accept_in_reset", 64'(accept_a), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_accept_after", 64'(accept_a), 64'(1));
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (ready_a !== 1'b0) bad++;
    end
    checkOutput("abort_no_ready", 64'(bad), 64'(0));
    v = randVec(0);
    applyStimulus(0, v, lat);
    checkResult("after_abort", 0, v, lat);
    ackResult("after_abort", 0);

    // Single-class instance: one result, then back-to-back with ack tied high.
    v = randVec(0);
    applyStimulus(2, v, lat);
    checkResult("n1", 2, v, lat);
    ackResult("n1", 2);
    v = randVec(0);
    @(negedge clk);
    vec_d = v[41:0];
    valid_d = 1'b1;
    ack_d = 1'b1;
    highs = 0;
    bad = 0;
    prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (ready_d === 1'b1) highs++;
      if (ready_d === prev) bad++;
      prev = ready_d;
    end
    checkOutput("n1_b2b_results", 64'(highs), 64'(10));
    checkOutput("n1_b2b_alternate", 64'(bad), 64'(0));
    checkOutput("n1_b2b_max", 64'(max_d), 64'(v[41:0]));
    @(negedge clk);
    valid_d = 1'b0;
    ack_d = 1'b0;

    // Random vectors: full range, small values with many ties, and extremes.
    for (int i = 0; i < 24; i++) begin
      v = randVec(i % 3);
      applyStimulus(0, v, lat);
      checkResult($sformatf("rand_a%0d", i), 0, v, lat);
      ackResult($sformatf("rand_a%0d", i), 0);
    end
    for (int i = 0; i < 15; i++) begin
      v = randVec(i % 3);
      applyStimulus(1, v, lat);
      checkResult($sformatf("rand_b%0d", i), 1, v, lat);
      ackResult($sformatf("rand_b%0d", i), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
